// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding word read, result held on inst/pc until consumed; 3 cycles/inst best case.
// Backpressure: no new request is issued while an instruction waits in HOLD for inst_ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  fetch_t      hold_q, hold_d;
  logic        redir;
  logic        handshake;

  assign redir     = redirect_valid && (state_q != S_HALT);
  assign handshake = (state_q == S_HOLD) && inst_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hold_d     = hold_q;

    case (state_q)
      S_REQ: begin
        // A granted request stays in flight even when redirected; its data must be drained.
        if (mem_gnt) state_d = redir ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redir) begin
          state_d = mem_rvalid ? S_REQ : S_DROP;
        end else if (mem_rvalid) begin
          state_d    = S_HOLD;
          hold_d     = '{pc: fetch_pc_q, inst: mem_rdata};
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
        end else if (handshake) begin
          state_d = (hold_q.inst == 32'h0) ? S_HALT : S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_REQ;
    endcase

    if (redir) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
    end
  end

  assign mem_req    = (state_q == S_REQ) && !rst;
  assign mem_addr   = fetch_pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = hold_q.inst;
  assign pc         = hold_q.pc;
  assign halted     = (state_q == S_HALT);

endmodule
